// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select encoding and default
// register-file geometry used by the hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    localparam int PC_REG_DEF = 15;
    localparam int RA_W_DEF   = 4;

    // The memory-stage producer is younger than writeback, so it wins.
    function automatic fwd_sel_t fwd_pick(input logic m_hit, input logic w_hit);
        if (m_hit) begin
            return FWD_M;
        end else if (w_hit) begin
            return FWD_W;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment
// and the value sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use and
// stall-only RAW interlocks, control-flow flushes and stall/flush counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int RA_W    = RA_W_DEF,
    parameter int PC_REG  = PC_REG_DEF,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0][RA_W-1:0]  RaD,
    input  logic [NUM_SRC-1:0][RA_W-1:0]  RaE,
    input  logic [RA_W-1:0]               RdE,
    input  logic [RA_W-1:0]               RdM,
    input  logic [RA_W-1:0]               RdW,
    input  logic                          RegWriteE,
    input  logic                          RegWriteM,
    input  logic                          RegWriteW,
    input  logic                          MemtoRegE,
    input  logic                          PCSrcD,
    input  logic                          PCSrcE,
    input  logic                          PCSrcM,
    input  logic                          PCSrcW,
    input  logic                          BranchTakenE,
    input  logic                          MemBusy,
    input  logic                          CntClr,
    output logic [NUM_SRC-1:0][1:0]       FwdE,
    output logic                          StallF,
    output logic                          StallD,
    output logic                          StallE,
    output logic                          StallM,
    output logic                          FlushD,
    output logic                          FlushE,
    output logic [CNT_W-1:0]              StallCnt,
    output logic [CNT_W-1:0]              FlushCnt
);

    localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);
    localparam bit              FWD_ON = (FWD_EN != 0);

    logic [NUM_SRC-1:0] m_hit;
    logic [NUM_SRC-1:0] w_hit;
    logic [NUM_SRC-1:0] ldr_hit;
    logic [NUM_SRC-1:0] raw_hit;
    logic               ldr_stall;
    logic               raw_stall;
    logic               pc_wr_pending;
    logic               flush_any;

    // Per-source producer matches; the PC is never a forwarding/interlock target.
    always_comb begin
        m_hit   = '0;
        w_hit   = '0;
        ldr_hit = '0;
        raw_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            m_hit[i]   = RegWriteM && (RdM == RaE[i]) && (RaE[i] != PC_IDX);
            w_hit[i]   = RegWriteW && (RdW == RaE[i]) && (RaE[i] != PC_IDX);
            ldr_hit[i] = MemtoRegE && RegWriteE && (RdE == RaD[i]) && (RaD[i] != PC_IDX);
            raw_hit[i] = (RaD[i] != PC_IDX) &&
                         ((RegWriteE && (RdE == RaD[i])) ||
                          (RegWriteM && (RdM == RaD[i])) ||
                          (RegWriteW && (RdW == RaD[i])));
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        assign FwdE[i] = (reset || !FWD_ON) ? FWD_REG : fwd_pick(m_hit[i], w_hit[i]);
    end

    // Without forwarding, any in-flight producer of a decode source interlocks.
    assign ldr_stall     = |ldr_hit;
    assign raw_stall     = !FWD_ON && (|raw_hit);
    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    // Reset forces bubbles into D/E and drops every hold immediately.
    assign StallF = !reset && (ldr_stall || raw_stall || pc_wr_pending || MemBusy);
    assign StallD = !reset && (ldr_stall || raw_stall || MemBusy);
    assign StallE = !reset && MemBusy;
    assign StallM = !reset && MemBusy;
    assign FlushD = reset || (!MemBusy && (pc_wr_pending || PCSrcW || BranchTakenE));
    assign FlushE = reset || (!MemBusy && (ldr_stall || raw_stall || BranchTakenE));

    assign flush_any = FlushD | FlushE;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (CntClr),
        .inc   (StallF),
        .count (StallCnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (CntClr),
        .inc   (flush_any),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one forwarding and one stall-only instance
// share stimulus and are checked against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int NS = 3;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam logic [RW-1:0] PC = 4'd15;
    localparam logic [CW-1:0] CMAX = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [NS-1:0][RW-1:0]  RaD, RaE;
    logic [RW-1:0]          RdE, RdM, RdW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemBusy, CntClr;

    logic [NS-1:0][1:0] fwd_a, fwd_b;
    logic sf_a, sd_a, se_a, sm_a, fd_a, fe_a;
    logic sf_b, sd_b, se_b, sm_b, fd_b, fe_b;
    logic [CW-1:0] sc_a, fc_a, sc_b, fc_b;

    hazard_ctrl #(.NUM_SRC(NS), .RA_W(RW), .PC_REG(15), .FWD_EN(1), .CNT_W(CW)) dut_fwd (
        .clk(clk), .reset(reset), .RaD(RaD), .RaE(RaE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemBusy(MemBusy), .CntClr(CntClr),
        .FwdE(fwd_a), .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .StallM(sm_a),
        .FlushD(fd_a), .FlushE(fe_a), .StallCnt(sc_a), .FlushCnt(fc_a));

    hazard_ctrl #(.NUM_SRC(NS), .RA_W(RW), .PC_REG(15), .FWD_EN(0), .CNT_W(CW)) dut_stl (
        .clk(clk), .reset(reset), .RaD(RaD), .RaE(RaE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemBusy(MemBusy), .CntClr(CntClr),
        .FwdE(fwd_b), .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .StallM(sm_b),
        .FlushD(fd_b), .FlushE(fe_b), .StallCnt(sc_b), .FlushCnt(fc_b));

    typedef struct packed {
        logic [NS-1:0][1:0] fwd;
        logic [3:0]         stall;   // F, D, E, M
        logic [1:0]         flush;   // D, E
        logic [CW-1:0]      sc;
        logic [CW-1:0]      fc;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [CW-1:0] m_sc_a, m_fc_a, m_sc_b, m_fc_b;

    function automatic obs_t model(input bit fwd_en, input logic [CW-1:0] sc, input logic [CW-1:0] fc);
        obs_t o;
        bit ldr, raw, pcw;
        o = '0;
        o.sc = sc;
        o.fc = fc;
        if (reset) begin
            o.flush = 2'b11;
            return o;
        end
        ldr = 0;
        raw = 0;
        for (int i = 0; i < NS; i++) begin
            if (fwd_en && RaE[i] != PC) begin
                if (RegWriteM && RdM == RaE[i])      o.fwd[i] = 2'b10;
                else if (RegWriteW && RdW == RaE[i]) o.fwd[i] = 2'b01;
            end
            if (RaD[i] != PC) begin
                if (MemtoRegE && RegWriteE && RdE == RaD[i]) ldr = 1;
                if (!fwd_en && ((RegWriteE && RdE == RaD[i]) || (RegWriteM && RdM == RaD[i]) ||
                                (RegWriteW && RdW == RaD[i]))) raw = 1;
            end
        end
        pcw = PCSrcD | PCSrcE | PCSrcM;
        o.stall = {ldr | raw | pcw | MemBusy, ldr | raw | MemBusy, MemBusy, MemBusy};
        if (!MemBusy) o.flush = {pcw | PCSrcW | BranchTakenE, ldr | raw | BranchTakenE};
        return o;
    endfunction

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c, input bit inc);
        if (reset || CntClr) return '0;
        if (inc && c != CMAX) return c + 1'b1;
        return c;
    endfunction

    // Inputs are already applied; record this cycle's expectation, then advance.
    task automatic cyc();
        exp_t e;
        #1;
        if (reset) begin
            m_sc_a = '0; m_fc_a = '0; m_sc_b = '0; m_fc_b = '0;
        end
        e.a = model(1'b1, m_sc_a, m_fc_a);
        e.b = model(1'b0, m_sc_b, m_fc_b);
        exp_q.push_back(e);
        m_sc_a = next_cnt(m_sc_a, e.a.stall[3]);
        m_fc_a = next_cnt(m_fc_a, |e.a.flush);
        m_sc_b = next_cnt(m_sc_b, e.b.stall[3]);
        m_fc_b = next_cnt(m_fc_b, |e.b.flush);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; RaD = '0; RaE = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
        BranchTakenE = 0; MemBusy = 0; CntClr = 0;
        RaD[0] = 4'd9; RaD[1] = 4'd10; RaD[2] = 4'd11;
        RaE[0] = 4'd12; RaE[1] = 4'd13; RaE[2] = 4'd14;
    endtask

    function automatic logic [RW-1:0] rreg();
        return ($urandom_range(0, 7) == 0) ? PC : RW'($urandom_range(0, 4));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("fwd.FwdE", 32'(fwd_a), 32'(e.a.fwd));
            chk("fwd.stall", {28'd0, sf_a, sd_a, se_a, sm_a}, 32'(e.a.stall));
            chk("fwd.flush", {30'd0, fd_a, fe_a}, 32'(e.a.flush));
            chk("fwd.StallCnt", 32'(sc_a), 32'(e.a.sc));
            chk("fwd.FlushCnt", 32'(fc_a), 32'(e.a.fc));
            chk("stl.FwdE", 32'(fwd_b), 32'(e.b.fwd));
            chk("stl.stall", {28'd0, sf_b, sd_b, se_b, sm_b}, 32'(e.b.stall));
            chk("stl.flush", {30'd0, fd_b, fe_b}, 32'(e.b.flush));
            chk("stl.StallCnt", 32'(sc_b), 32'(e.b.sc));
            chk("stl.FlushCnt", 32'(fc_b), 32'(e.b.fc));
        end
    end

    initial begin
        idle();
        reset = 1;
        m_sc_a = '0; m_fc_a = '0; m_sc_b = '0; m_fc_b = '0;
        @(posedge clk);
        #1;
        cyc(); cyc();
        idle();
        cyc();

        // Forwarding priority and PC exclusion
        RdM = 4'd3; RegWriteM = 1; RdW = 4'd3; RegWriteW = 1; RaE[0] = 4'd3;
        cyc();
        RaE[0] = 4'd15; RdM = 4'd15; RdW = 4'd15;
        cyc();
        RdM = 4'd6; RaE[1] = 4'd4; RdW = 4'd4;
        cyc();
        idle(); CntClr = 1; cyc(); idle();

        // Load-use: one stall cycle then clear
        MemtoRegE = 1; RegWriteE = 1; RdE = 4'd5; RaD[1] = 4'd5;
        cyc();
        idle();
        cyc();

        // Stall-only RAW with the producer walking E -> M -> W
        RegWriteE = 1; RdE = 4'd2; RaD[0] = 4'd2; cyc();
        RegWriteE = 0; RdE = 4'd0; RegWriteM = 1; RdM = 4'd2; cyc();
        RegWriteM = 0; RdM = 4'd0; RegWriteW = 1; RdW = 4'd2; cyc();
        idle(); cyc();

        // PC write walking D -> W from cleared counters
        CntClr = 1; cyc(); idle();
        PCSrcD = 1; cyc();
        PCSrcD = 0; PCSrcE = 1; cyc();
        PCSrcE = 0; PCSrcM = 1; cyc();
        PCSrcM = 0; PCSrcW = 1; cyc();
        idle(); cyc();

        // Branch held across a busy memory, flushing only on release
        BranchTakenE = 1; MemBusy = 1; cyc(); cyc();
        MemBusy = 0; cyc();
        idle(); cyc();

        // Branch together with a load-use hazard
        BranchTakenE = 1; MemtoRegE = 1; RegWriteE = 1; RdE = 4'd7; RaD[2] = 4'd7;
        cyc();
        idle();

        // Saturation, then clear against a pending increment
        PCSrcD = 1;
        repeat (20) cyc();
        CntClr = 1; cyc();
        CntClr = 0; cyc();
        idle();

        // Reset mid-stall
        MemtoRegE = 1; RegWriteE = 1; RdE = 4'd1; RaD[0] = 4'd1; MemBusy = 1; cyc();
        reset = 1; cyc();
        reset = 0; cyc();
        idle(); cyc();

        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            CntClr       = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NS; i++) begin
                RaD[i] = rreg();
                RaE[i] = rreg();
            end
            RdE          = rreg();
            RdM          = rreg();
            RdW          = rreg();
            RegWriteE    = 1'($urandom_range(0, 1));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = 1'($urandom_range(0, 1));
            PCSrcD       = ($urandom_range(0, 7) == 0);
            PCSrcE       = ($urandom_range(0, 7) == 0);
            PCSrcM       = ($urandom_range(0, 7) == 0);
            PCSrcW       = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            MemBusy      = ($urandom_range(0, 3) == 0);
            cyc();
        end
        idle();

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter NUM_SRC, default 3: number of register read sources per instruction.
REQ-003 Parameter RA_W, default 4: register address width.
REQ-004 Parameter PC_REG, default 15: register index that is never forwarded.
REQ-005 Parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-006 Parameter CNT_W, default 32: performance counter width.
REQ-007 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-high reset
- RaD  in  NUM_SRC x RA_W  decode-stage source registers
- RaE  in  NUM_SRC x RA_W  execute-stage source registers
- RdE, RdM, RdW  in  RA_W each  destination registers
- RegWriteE, RegWriteM, RegWriteW  in  1 each  write enables
- MemtoRegE  in  1  load in execute
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  PC-write in flight
- BranchTakenE  in  1  branch resolved taken
- MemBusy  in  1  data memory not ready
- CntClr  in  1  synchronous counter clear
- FwdE  out  NUM_SRC x 2  per-source select: 00 reg, 01 W, 10 M
- StallF, StallD, StallE, StallM  out  1 each  stage hold
- FlushD, FlushE  out  1 each  bubble insertion
- StallCnt, FlushCnt  out  CNT_W each  saturating performance counters

Function
REQ-008 FwdE[i] SHALL be 10 when FWD_EN=1, RegWriteM=1, RdM==RaE[i] and RaE[i]!=PC_REG; otherwise 01 on the same test against W; otherwise 00. M has priority over W.
REQ-009 When FWD_EN=0, FwdE SHALL be 00 for all sources.
REQ-010 ldrStall SHALL equal MemtoRegE & RegWriteE & (RdE==RaD[i] for any i), with RaD[i]!=PC_REG.
REQ-011 When FWD_EN=0, rawStall SHALL assert while any RaD[i] (not PC_REG) matches RdE, RdM or RdW with the corresponding RegWrite set. The stall lasts multiple cycles, until the producer leaves W.
REQ-012 PCWrPending SHALL equal PCSrcD | PCSrcE | PCSrcM.
REQ-013 StallF SHALL equal ldrStall | rawStall | PCWrPending | MemBusy.
REQ-014 StallD SHALL equal ldrStall | rawStall | MemBusy.
REQ-015 StallE and StallM SHALL equal MemBusy.
REQ-016 FlushD SHALL equal ~MemBusy & (PCWrPending | PCSrcW | BranchTakenE).
REQ-017 FlushE SHALL equal ~MemBusy & (ldrStall | rawStall | BranchTakenE).
REQ-018 While MemBusy=1 no flush SHALL occur. A held BranchTakenE SHALL flush in the first cycle after MemBusy falls, and only then.
REQ-019 Simultaneous BranchTakenE and ldrStall: FlushD=FlushE=1, StallD=1. The branch flush dominates the decode contents.
REQ-020 StallCnt SHALL increment by 1 on each rising clk edge where StallF=1.
REQ-021 FlushCnt SHALL increment by 1 on each rising clk edge where FlushD|FlushE=1.
REQ-022 Both counters SHALL saturate at all-ones and not wrap.
REQ-023 CntClr=1 SHALL zero both counters at the next edge and SHALL take precedence over a simultaneous increment.
REQ-024 All outputs other than the counters SHALL be combinational, with zero-cycle latency.

Reset
REQ-025 While reset=1: StallCnt=FlushCnt=0, FlushD=FlushE=1, StallF=StallD=StallE=StallM=0, FwdE=00.
REQ-026 Reset asserted mid-stall SHALL abandon the stall immediately.
REQ-027 After reset deasserts, the first edge SHALL count only on the REQ-020/021 conditions.

Structure
REQ-028 Shared package pipe_pkg SHALL hold:
- fwd_sel_t enum: FWD_REG=00, FWD_W=01, FWD_M=10
- PC_REG default constant
- RA_W default constant
REQ-029 The counters SHALL use one sub-module, sat_counter: parameter CNT_W; ports clk, reset, clr, inc, count. It is instantiated twice.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- RdM=3, RegWriteM=1, RdW=3, RegWriteW=1, RaE[0]=3 -> FwdE[0]=10. Same with RaE[0]=15 -> 00.
- MemtoRegE=1, RegWriteE=1, RdE=5, RaD[1]=5 -> one cycle StallF=StallD=FlushE=1, StallCnt 0->1. Next cycle all clear.
- FWD_EN=0, RegWriteE=1, RdE=2, RaD[0]=2, producer advancing E->M->W -> stall held 3 cycles, then clear.
- PCSrcD=1 advancing D->W -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles, FlushCnt=4.
- MemBusy=1 for 2 cycles with BranchTakenE=1 -> no flush during busy; FlushD=FlushE=1 in the release cycle.
- Counter preset near all-ones with StallF=1 -> holds all-ones. CntClr=1 with StallF=1 -> 0.
